// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types, widths and helpers for the strobe decoder
//
// Purpose : state encoding, default code/output widths and the one-hot helper
//           used by decoder_strobe.
// Ports   : none (package).
package decoder_pkg;

  localparam int DEC_CODE_W = 3;
  localparam int DEC_OUT_W  = 2 ** DEC_CODE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GUARD = 2'd2
  } dec_state_e;

  // Zero-extended index into a single set bit; every code value is legal.
  function automatic logic [DEC_OUT_W-1:0] onehot_of(input logic [DEC_CODE_W-1:0] code);
    logic [DEC_OUT_W-1:0] r;
    r       = '0;
    r[code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// rtl/hold_counter.sv - loadable down-counter with zero flag
//
// Purpose : counts remaining hold cycles; load has priority over dec and the
//           count saturates at zero.
// Ports   : clk, rst_n (async active-low), load/load_val (preset),
//           dec (decrement request), zero (count is zero).
module hold_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_strobe.sv
// rtl/decoder_strobe.sv - sequential 3-to-8 one-hot decoder with guarded strobes
//
// Purpose : each accepted code drives one output line for HOLD cycles, then a
//           single all-zero guard cycle with a done pulse.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_code/in_ready : code input handshake
//           abort                     : synchronous cancel of the current strobe
//           out_onehot/out_active     : registered one-hot output and its OR
//           done                      : one-cycle pulse at the end of a strobe
module decoder_strobe
  import decoder_pkg::*;
#(
  parameter int CODE_W = DEC_CODE_W,
  parameter int HOLD   = 4,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CODE_W-1:0]    in_code,
  output logic                 in_ready,
  input  logic                 abort,
  output logic [2**CODE_W-1:0] out_onehot,
  output logic                 out_active,
  output logic                 done
);

  localparam int OUT_W = 2 ** CODE_W;

  dec_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [OUT_W-1:0]  onehot_q, onehot_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  // Counter is preset to HOLD-1 on accept, so DRIVE lasts exactly HOLD cycles.
  hold_counter #(
    .CNT_W (CNT_W)
  ) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_W'(HOLD - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    onehot_d = onehot_q;
    active_d = active_q;
    done_d   = done_q;
    ready_d  = ready_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        done_d  = 1'b0;
        ready_d = 1'b1;
        if (in_valid && ready_q) begin
          state_d  = DRIVE;
          code_d   = in_code;
          onehot_d = onehot_of(in_code);
          active_d = 1'b1;
          ready_d  = 1'b0;
          cnt_load = 1'b1;
        end
      end
      DRIVE: begin
        // in_valid is deliberately not looked at here: no queueing of codes.
        if (cnt_zero || abort) begin
          state_d  = GUARD;
          onehot_d = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          onehot_d = onehot_of(code_q);
          cnt_dec  = 1'b1;
        end
      end
      GUARD: begin
        state_d  = IDLE;
        done_d   = 1'b0;
        ready_d  = 1'b1;
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
        active_d = 1'b0;
        done_d   = 1'b0;
        ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      onehot_q <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      onehot_q <= onehot_d;
      active_q <= active_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_active = active_q;
  assign done       = done_q;
  assign in_ready   = ready_q;

endmodule
